// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS31 (x^31 + x^28 + 1) bit-error checker.
package prbs_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  localparam int DEF_LOCK_THRESH = 64;
  localparam int DEF_WIN         = 256;
  localparam int DEF_UNLOCK_ERRS = 16;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/prbs31_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 self-synchronising bit-error checker with lock/unlock FSM and windowed error monitor.
// Build option: define PRBS31_CHK_INVERT_EN to invert serial_in before all processing.
//
// state     | meaning
// ST_SEED   | filling the 31-bit history from the line
// ST_HUNT   | checking line against predictor, counting consecutive matches
// ST_LOCKED | predictor free-runs, mismatches counted as bit errors
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int WIN         = DEF_WIN,
  parameter int UNLOCK_ERRS = DEF_UNLOCK_ERRS,
  parameter int CNT_W       = 32
) (
  input  logic             qzt_clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MW = 10;
  localparam int WW = 16;
  localparam logic [MW-1:0] LOCK_T    = MW'(LOCK_THRESH);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);
  localparam logic [WW-1:0] UNLOCK_T  = WW'(UNLOCK_ERRS);
  localparam logic [4:0]    SEED_LAST = 5'(PRBS_LEN - 1);

  chk_state_e          state_q, state_d;
  logic [PRBS_LEN-1:0] hist_q, hist_d;
  logic [4:0]          seed_cnt_q, seed_cnt_d;
  logic [MW-1:0]       match_q, match_d, match_inc;
  logic [WW-1:0]       win_cnt_q, win_cnt_d;
  logic [WW-1:0]       win_err_q, win_err_d, win_err_inc;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                bit_in, pred, mismatch, bit_inc, err_inc;

`ifdef PRBS31_CHK_INVERT_EN
  assign bit_in = ~serial_in;
`else
  assign bit_in = serial_in;
`endif

  assign pred        = hist_q[TAP_A] ^ hist_q[TAP_B];
  assign mismatch    = bit_in ^ pred;
  assign match_inc   = match_q + 1'b1;
  assign win_err_inc = win_err_q + WW'(mismatch);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    bit_inc     = 1'b0;
    err_inc     = 1'b0;
    if (en) begin
      case (state_q)
        ST_SEED: begin
          hist_d = {hist_q[PRBS_LEN-2:0], bit_in};
          if (seed_cnt_q == SEED_LAST) begin
            state_d    = ST_HUNT;
            seed_cnt_d = '0;
            match_d    = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        ST_HUNT: begin
          hist_d = {hist_q[PRBS_LEN-2:0], bit_in};
          // an all-zero history predicts 0 forever, so it must never build up matches
          if (!mismatch && (hist_q != '0)) begin
            match_d = match_inc;
            if (match_inc == LOCK_T) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              match_d   = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          hist_d      = {hist_q[PRBS_LEN-2:0], pred};
          bit_inc     = 1'b1;
          err_inc     = mismatch;
          err_pulse_d = mismatch;
          if (win_err_inc == UNLOCK_T) begin
            state_d    = ST_SEED;
            locked_d   = 1'b0;
            hist_d     = '0;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_inc;
          end
        end
        default: begin
          state_d = ST_SEED;
        end
      endcase
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q     <= ST_SEED;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (qzt_clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clr_cnt),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (qzt_clk),
    .reset (reset),
    .inc   (bit_inc),
    .clr   (clr_cnt),
    .count (bit_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: directed scenarios plus randomized traffic against a queue-based model.
module tb_prbs31_checker;

  localparam int LOCK_THRESH = 64;
  localparam int WIN         = 256;
  localparam int UNLOCK_ERRS = 16;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int M_SEED = 0, M_HUNT = 1, M_LOCK = 2;

  logic             qzt_clk = 1'b0;
  logic             reset = 1'b1;
  logic             serial_in = 1'b0;
  logic             en = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             locked, err_pulse;
  logic [CNT_W-1:0] err_count, bit_count;

  always #5 qzt_clk = ~qzt_clk;

  prbs31_checker #(
    .LOCK_THRESH (LOCK_THRESH),
    .WIN         (WIN),
    .UNLOCK_ERRS (UNLOCK_ERRS),
    .CNT_W       (CNT_W)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .serial_in (serial_in),
    .en        (en),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference generator: b[n] = b[n-31] ^ b[n-28]
  logic [30:0] gen = 31'h1;
  task automatic gen_bit(output bit b);
    b   = gen[30] ^ gen[27];
    gen = {gen[29:0], b};
  endtask

  // behavioural model: history as a queue, newest bit at index 0
  bit mh[$];
  int m_mode, m_seen, m_match, m_wbits, m_werr, m_bits, m_errs;
  bit m_locked, m_pulse;

  task automatic model_clear_hist();
    mh.delete();
    for (int i = 0; i < 31; i++) mh.push_back(1'b0);
  endtask

  task automatic model_reset();
    model_clear_hist();
    m_mode = M_SEED; m_seen = 0; m_match = 0; m_wbits = 0; m_werr = 0;
    m_bits = 0; m_errs = 0; m_locked = 0; m_pulse = 0;
  endtask

  task automatic model_push(input bit b);
    mh.push_front(b);
    void'(mh.pop_back());
  endtask

  task automatic model_step(input bit rx, input bit e, input bit c);
    bit b, p, nz;
    m_pulse = 0;
`ifdef PRBS31_CHK_INVERT_EN
    b = ~rx;
`else
    b = rx;
`endif
    if (e) begin
      p  = mh[30] ^ mh[27];
      nz = 0;
      foreach (mh[i]) if (mh[i]) nz = 1;
      if (m_mode == M_SEED) begin
        model_push(b);
        m_seen++;
        if (m_seen == 31) begin m_mode = M_HUNT; m_match = 0; end
      end else if (m_mode == M_HUNT) begin
        model_push(b);
        if (b == p && nz) begin
          m_match++;
          if (m_match == LOCK_THRESH) begin
            m_mode = M_LOCK; m_locked = 1; m_wbits = 0; m_werr = 0;
          end
        end else m_match = 0;
      end else begin
        model_push(p);
        if (m_bits < CNT_MAX) m_bits++;
        if (b != p) begin
          m_pulse = 1;
          if (m_errs < CNT_MAX) m_errs++;
          m_werr++;
        end
        m_wbits++;
        if (m_werr == UNLOCK_ERRS) begin
          m_mode = M_SEED; m_locked = 0; m_seen = 0; m_wbits = 0; m_werr = 0;
          model_clear_hist();
        end else if (m_wbits == WIN) begin
          m_wbits = 0; m_werr = 0;
        end
      end
    end
    if (c) begin m_bits = 0; m_errs = 0; end
  endtask

  int vbits = 0;
  int lock_at = -1;
  int unlock_at = -1;
  int pulses = 0;
  int lock_cycles = 0;

  task automatic cyc(input bit rx, input bit e, input bit c);
    logic prev_locked;
    reset = 1'b0; serial_in = rx; en = e; clr_cnt = c;
    model_step(rx, e, c);
    prev_locked = locked;
    @(posedge qzt_clk);
    #1;
    if (e) vbits++;
    if (locked === 1'b1 && prev_locked !== 1'b1) lock_at = vbits;
    if (locked !== 1'b1 && prev_locked === 1'b1) unlock_at = vbits;
    if (err_pulse === 1'b1) pulses++;
    if (locked === 1'b1) lock_cycles++;
    check("locked", locked, m_locked);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, m_errs);
    check("bit_count", bit_count, m_bits);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; clr_cnt = 1'b0; serial_in = 1'b0;
    repeat (2) @(posedge qzt_clk);
    #1;
    model_reset();
    vbits = 0; lock_at = -1; unlock_at = -1; pulses = 0; lock_cycles = 0;
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_bit_count", bit_count, 0);
  endtask

  task automatic send_clean(input int n, input bit inv, input bit stop_on_lock);
    bit b;
    for (int i = 0; i < n; i++) begin
      if (stop_on_lock && lock_at >= 0) break;
      gen_bit(b);
      cyc(b ^ inv, 1'b1, 1'b0);
    end
  endtask

  task automatic send_flip(input bit c);
    bit b;
    gen_bit(b);
    cyc(~b, 1'b1, c);
  endtask

  initial begin
    int mark;
    bit b;

    // 1: clean lock after 31 + LOCK_THRESH valid bits
    do_reset();
    send_clean(400, 1'b0, 1'b1);
    check("t1_lock_at", lock_at, 95);
    check("t1_err_count", err_count, 0);
    send_clean(40, 1'b0, 1'b0);
    check("t1_bit_count", bit_count, 40);

    // 2: single flipped bit
    pulses = 0;
    send_clean(10, 1'b0, 1'b0);
    send_flip(1'b0);
    send_clean(20, 1'b0, 1'b0);
    check("t2_pulses", pulses, 1);
    check("t2_err_count", err_count, 1);
    check("t2_locked", locked, 1);

    // 3: mid-operation reset, then 16 spread errors force unlock, then relock
    do_reset();
    send_clean(400, 1'b0, 1'b1);
    check("t3_lock_at", lock_at, 95);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      send_clean(11, 1'b0, 1'b0);
      send_flip(1'b0);
      if (k == 15) check("t3_locked_after_15", locked, 1);
    end
    check("t3_locked_after_16", locked, 0);
    check("t3_err_count", err_count, 16);
    check("t3_pulses", pulses, 16);
    mark = vbits;
    lock_at = -1;
    send_clean(400, 1'b0, 1'b1);
    check("t3_relock_bits", lock_at - mark, 95);
    check("t3_err_retained", err_count, 16);

    // 4: stuck-at-0 line
    do_reset();
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b1, 1'b0);
    check("t4_lock_cycles", lock_cycles, 0);
    check("t4_err_count", err_count, 0);
    check("t4_bit_count", bit_count, 0);

    // 5: en toggling, then clr_cnt coincident with an error and with en=0
    do_reset();
    for (int i = 0; i < 600 && lock_at < 0; i++) begin
      if (i % 2 == 0) begin
        gen_bit(b);
        cyc(b, 1'b1, 1'b0);
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("t5_lock_at", lock_at, 95);
    send_clean(5, 1'b0, 1'b0);
    send_flip(1'b1);
    check("t5_clr_err_count", err_count, 0);
    check("t5_clr_err_pulse", err_pulse, 1);
    check("t5_clr_bit_count", bit_count, 0);
    send_clean(7, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("t5_idle_clr_bit_count", bit_count, 0);
    check("t5_idle_err_pulse", err_pulse, 0);

    // randomized traffic: sparse errors, then a dense burst, then clean
    for (int ph = 0; ph < 3; ph++) begin
      int flip_pct;
      flip_pct = (ph == 1) ? 15 : ((ph == 0) ? 1 : 0);
      for (int i = 0; i < 1500; i++) begin
        bit e, c, f;
        e = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 299) == 0);
        f = (int'($urandom_range(0, 99)) < flip_pct);
        if (e) begin
          gen_bit(b);
          cyc(b ^ f, 1'b1, c);
        end else begin
          cyc(1'($urandom_range(0, 1)), 1'b0, c);
        end
      end
    end
    check("rand_final_locked", locked, 1);

    // 6: polarity-inverted stream
    do_reset();
`ifdef PRBS31_CHK_INVERT_EN
    send_clean(2000, 1'b1, 1'b1);
    check("t6_inv_lock_at", lock_at, 95);
`else
    send_clean(2000, 1'b1, 1'b0);
    check("t6_inv_lock_cycles", lock_cycles, 0);
    check("t6_inv_lock_at", lock_at, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
